dmem_responder: RTL and testbench

Word-addressed 16-bit data memory that answers load/store requests from the pipelined CPU. The CPU's MEM stage is the initiator and drives a request/ready handshake. This block is the responder: it holds the storage array, inserts a programmable number of wait states, and returns read data or commits write data. All state updates on the falling edge of `clock`, matching the CPU pipeline registers.

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed 16-bit data memory responding to the CPU MEM
// stage over a req/ready handshake, with a programmable number of wait states.
// All sequential logic runs on the falling edge of clock.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic [15:0] rdata,
  output logic        err
);

  // Index width into the storage array; at least one bit so the slice is legal.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = WAIT_STATES[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [15:0]   mem_rd;
  logic          legal;

  // Storage is deliberately not reset: committed stores survive a reset.
  logic [15:0] mem [DEPTH];

  // The access is legal when halfword-aligned and the word index is in range.
  assign legal   = (addr_q[0] == 1'b0) && (32'(addr_q[15:1]) < DEPTH);
  assign mem_idx = addr_q[AW:1];
  assign mem_rd  = mem[mem_idx];

  // Next-state logic: capture in IDLE, count wait states in BUSY, execute the
  // access on the BUSY->RESP edge, then always return to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = WAIT_LOAD;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          ready_d = 1'b1;
          if (legal) begin
            err_d = 1'b0;
            if (we_q) begin
              mem_we  = 1'b1;
              rdata_d = 16'h0000;
            end else begin
              rdata_d = mem_rd;
            end
          end else begin
            err_d   = 1'b1;
            rdata_d = 16'h0000;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; reset drops any in-flight request at once.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      ready_q <= 1'b0;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store commit; only ever enabled on the BUSY->RESP edge of a legal store.
  always_ff @(negedge clock) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_STATES=2 instance driven from a
// vector table plus hand sequences, and a WAIT_STATES=0 instance for
// back-to-back requests with req held high. Outputs are sampled on posedge.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [15:0] addr0 = 16'h0, wdata0 = 16'h0;
  logic        ready0, err0;
  logic [15:0] rdata0;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr1 = 16'h0, wdata1 = 16'h0;
  logic        ready1, err1;
  logic [15:0] rdata1;

  dmem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut0 (
    .clock(clk), .reset_n(rst_n), .req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .ready(ready0), .rdata(rdata0), .err(err0)
  );

  dmem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut1 (
    .clock(clk), .reset_n(rst_n), .req(req1), .we(we1), .addr(addr1),
    .wdata(wdata1), .ready(ready1), .rdata(rdata1), .err(err1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One access on dut0: returns after the posedge following the return to IDLE.
  task automatic run0(input vec_t v, input string name);
    int got;
    logic [15:0] rd_keep;
    logic        er_keep;
    @(posedge clk);
    req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    @(negedge clk);               // E0: capture
    got = -1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      @(posedge clk);
      if (ready0 === 1'b1) begin
        got = e;
        break;
      end
    end
    req0 = 1'b0;
    chk({name, " latency"}, 16'(got), 16'd3);
    chk({name, " rdata"}, rdata0, v.exp_rdata);
    chk({name, " err"}, 16'(err0), 16'(v.exp_err));
    rd_keep = rdata0;
    er_keep = err0;
    @(negedge clk);
    @(posedge clk);
    chk({name, " ready pulse width"}, 16'(ready0), 16'd0);
    chk({name, " rdata hold"}, rdata0, rd_keep);
    chk({name, " err hold"}, 16'(err0), 16'(er_keep));
    $display("txn %s we=%0b addr=%h wdata=%h -> latency=%0d rdata=%h err=%0b",
             name, v.we, v.addr, v.wdata, got, rd_keep, er_keep);
  endtask

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 16'h0010, 16'h00F7, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'h00F7, 1'b0};
    vecs[2]  = '{1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 16'h0020, 16'h0016, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 16'h0200, 16'hFFFF, 16'h0000, 1'b1};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0};
    vecs[6]  = '{1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1};
    vecs[7]  = '{1'b0, 16'h0010, 16'h0000, 16'h00F7, 1'b0};
    vecs[8]  = '{1'b1, 16'h01FE, 16'hBEEF, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 16'h01FE, 16'h0000, 16'hBEEF, 1'b0};
    vecs[10] = '{1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1};
    vecs[11] = '{1'b1, 16'h8001, 16'h5555, 16'h0000, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    chk("reset ready0", 16'(ready0), 16'd0);
    chk("reset rdata0", rdata0, 16'h0000);
    chk("reset err0", 16'(err0), 16'd0);
    chk("reset ready1", 16'(ready1), 16'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven accesses on the WAIT_STATES=2 instance
    for (int i = 0; i < 12; i++) begin
      run0(vecs[i], $sformatf("vec%0d", i));
    end

    // Address/data changes during BUSY must be ignored (LW 0x0010 -> 00F7)
    begin
      int got;
      @(posedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; wdata0 = 16'h0000;
      @(negedge clk);             // E0
      @(negedge clk);             // E1
      @(posedge clk);
      addr0 = 16'h0030; we0 = 1'b1; wdata0 = 16'hDEAD;
      got = -1;
      for (int e = 2; e <= 8; e++) begin
        @(negedge clk);
        @(posedge clk);
        if (ready0 === 1'b1) begin
          got = e;
          break;
        end
      end
      req0 = 1'b0;
      chk("busy-change latency", 16'(got), 16'd3);
      chk("busy-change rdata", rdata0, 16'h00F7);
      chk("busy-change err", 16'(err0), 16'd0);
      $display("txn busy-change LW 0x0010 (addr->0x0030 after E1) -> rdata=%h err=%0b", rdata0, err0);
      @(negedge clk);
      @(posedge clk);
    end
    // 0x0030 was not written by the ignored store: 0x0010 still holds 00F7
    run0('{1'b0, 16'h0010, 16'h0000, 16'h00F7, 1'b0}, "post-change LW 0x0010");

    // Reset during the 2nd BUSY cycle of SW 0x0020 <- 1234
    @(posedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h1234;
    @(negedge clk);               // E0
    @(negedge clk);               // E1: now in 2nd BUSY cycle
    @(posedge clk);
    chk("pre-reset rdata", rdata0, 16'h00F7);
    rst_n = 1'b0;
    #1;
    chk("async reset ready", 16'(ready0), 16'd0);
    chk("async reset rdata", rdata0, 16'h0000);
    chk("async reset err", 16'(err0), 16'd0);
    req0 = 1'b0;
    $display("txn reset mid SW 0x0020<-1234 -> ready=%0b rdata=%h err=%0b", ready0, rdata0, err0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run0('{1'b0, 16'h0020, 16'h0000, 16'h0016, 1'b0}, "after-reset LW 0x0020");

    // WAIT_STATES=0, req held high: captures at E0,E3,E6; ready after E1,E4,E7
    @(posedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0002; wdata1 = 16'h0007;
    @(negedge clk);               // E0: first capture
    @(posedge clk);
    chk("b2b ready after E0", 16'(ready1), 16'd0);
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      @(posedge clk);
      chk($sformatf("b2b ready after E%0d", e), 16'(ready1), ((e % 3) == 1) ? 16'd1 : 16'd0);
      if (e == 1) begin
        chk("b2b SW 0x0002 err", 16'(err1), 16'd0);
        we1 = 1'b1; addr1 = 16'h0004; wdata1 = 16'h0008;
      end else if (e == 4) begin
        chk("b2b SW 0x0004 err", 16'(err1), 16'd0);
        we1 = 1'b0; addr1 = 16'h0004; wdata1 = 16'h0000;
      end else if (e == 7) begin
        chk("b2b LW 0x0004 rdata", rdata1, 16'h0008);
        chk("b2b LW 0x0004 err", 16'(err1), 16'd0);
        req1 = 1'b0;
      end
    end
    $display("txn b2b WS=0 SW 0x0002<-0007, SW 0x0004<-0008, LW 0x0004 -> rdata=%h", rdata1);

    // LW 0x0002 on the WAIT_STATES=0 instance: ready one edge after capture
    @(posedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
    @(negedge clk);               // E0
    @(negedge clk);               // E1
    @(posedge clk);
    req1 = 1'b0;
    chk("ws0 LW 0x0002 ready", 16'(ready1), 16'd1);
    chk("ws0 LW 0x0002 rdata", rdata1, 16'h0007);
    $display("txn ws0 LW 0x0002 -> ready=%0b rdata=%h", ready1, rdata1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
